// File: rtl/idct_pkg.sv
// idct_pkg: shared constants for the 8x8 / 4x4 IDCT.
//   Mode encodings, frame lengths, output start offsets, the 12-bit
//   fixed-point fraction, accumulator width and the DCT basis tables
//   C(k,n) = round(a(k)*cos((2n+1)k*pi/2N)*4096), indexed [k][n].
package idct_pkg;

    typedef enum logic [1:0] {
        MODE_4X4  = 2'b00,
        MODE_8X8  = 2'b01,
        MODE_RSV2 = 2'b10,
        MODE_RSV3 = 2'b11
    } mode_e;

    localparam logic [7:0] FLEN8 = 8'd149;
    localparam logic [7:0] FLEN4 = 8'd45;
    localparam logic [7:0] OFF8  = 8'd80;
    localparam logic [7:0] OFF4  = 8'd24;

    localparam int FRAC  = 12;
    localparam int ACC_W = 33;

    localparam int C8 [8][8] = '{
        '{ 1448,  1448,  1448,  1448,  1448,  1448,  1448,  1448},
        '{ 2009,  1703,  1138,   400,  -400, -1138, -1703, -2009},
        '{ 1892,   784,  -784, -1892, -1892,  -784,   784,  1892},
        '{ 1703,  -400, -2009, -1138,  1138,  2009,   400, -1703},
        '{ 1448, -1448, -1448,  1448,  1448, -1448, -1448,  1448},
        '{ 1138, -2009,   400,  1703, -1703,  -400,  2009, -1138},
        '{  784, -1892,  1892,  -784,  -784,  1892, -1892,   784},
        '{  400, -1138,  1703, -2009,  2009, -1703,  1138,  -400}
    };

    localparam int C4 [4][4] = '{
        '{ 2048,  2048,  2048,  2048},
        '{ 2676,  1108, -1108, -2676},
        '{ 2048, -2048, -2048,  2048},
        '{ 1108, -2676,  2676, -1108}
    };

    // Basis coefficient; outside the 4-point table it is 0 so a fixed
    // 8-wide dot product naturally reduces to a 4-point one.
    function automatic logic [13:0] coef(input logic is8, input logic [2:0] k, input logic [2:0] n);
        return is8 ? 14'(C8[k][n]) : (k[2] | n[2]) ? 14'd0 : 14'(C4[k[1:0]][n[1:0]]);
    endfunction

    // Map a row-major sample index to {row[2:0], col[2:0]} in the 8x8 storage;
    // 4x4 blocks occupy the upper-left quadrant.
    function automatic logic [5:0] pos(input logic is8, input logic [5:0] j);
        return is8 ? j : {1'b0, j[3:2], 1'b0, j[1:0]};
    endfunction

endpackage

// File: rtl/idct_mac_row.sv
// idct_mac_row: one 8-term signed dot product with round, shift and limit.
//   a : 8 x 16-bit signed samples, element i at a[i*16 +: 16]
//   c : 8 x 14-bit signed coefficients, element i at c[i*14 +: 14]
//   y : 16-bit result = limit((sum a*c + 2048) >>> 12)
//   IDCT_SAT_EN defined: limit saturates to [-32768, 32767];
//   otherwise the result wraps to 16 bits.
module idct_mac_row
    import idct_pkg::*;
(
    input  logic [127:0] a,
    input  logic [111:0] c,
    output logic [15:0]  y
);

    logic signed [29:0]           prod [8];
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-FRAC-1:0] sh;
    logic                         unused_bits;

    always_comb begin
        acc = ACC_W'(1 << (FRAC - 1));
        for (int i = 0; i < 8; i++) begin
            prod[i] = $signed(a[i*16 +: 16]) * $signed(c[i*14 +: 14]);
            acc     = acc + ACC_W'(prod[i]);
        end
        // dropping the fraction bits of a signed value is an arithmetic shift
        sh = acc[ACC_W-1:FRAC];
`ifdef IDCT_SAT_EN
        y = (sh > 21'sd32767) ? 16'h7fff : (sh < -21'sd32768) ? 16'h8000 : sh[15:0];
`else
        y = sh[15:0];
`endif
    end

    assign unused_bits = ^{acc[FRAC-1:0], sh[ACC_W-FRAC-1:16]};

endmodule

// File: rtl/idct_top.sv
// idct_top: streaming 2-D IDCT, 8x8 (mode 01) or 4x4 (mode 00).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all state and dout
//   mode  : 01 = 8x8, 00 = 4x4, 10/11 reserved (idle, dout = 0)
//   data  : signed coefficient, row-major, taken at f = 0 .. N*N-1
//   dout  : registered signed sample k, loaded at the edge where f = OFF+k
//   IDCT_SAT_EN: selects saturating instead of wrapping pass results.
// Frame counter f restarts at 0 on any mode change. Rows of the input
// block are transformed one coefficient per clock starting at f = N (row u
// is complete by then), into the transpose array; the column pass runs
// on the fly as each output sample is due.
module idct_top
    import idct_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    input  logic [15:0] data,
    output logic [15:0] dout
);

    logic [1:0]   mode_q;
    logic [7:0]   f_cnt, f_cur, f_nxt, flen, off, npt, nsq;
    logic         run, is8, in_en, row_en, out_en;
    logic [5:0]   ipos, rpos, opos;
    logic [15:0]  xin [8][8];
    logic [15:0]  tr  [8][8];
    logic [127:0] a_row, a_col;
    logic [111:0] c_row, c_col;
    logic [15:0]  row_y, col_y;

    always_comb begin
        run    = (mode == MODE_8X8) || (mode == MODE_4X4);
        is8    = mode == MODE_8X8;
        flen   = is8 ? FLEN8 : FLEN4;
        off    = is8 ? OFF8 : OFF4;
        npt    = is8 ? 8'd8 : 8'd4;
        nsq    = is8 ? 8'd64 : 8'd16;
        f_cur  = (!run || mode != mode_q) ? 8'd0 : f_cnt;
        f_nxt  = (!run || f_cur == flen - 8'd1) ? 8'd0 : f_cur + 8'd1;
        in_en  = run && f_cur < nsq;
        row_en = run && f_cur >= npt && f_cur < npt + nsq;
        out_en = run && f_cur >= off && f_cur < off + nsq;
        ipos   = pos(is8, f_cur[5:0]);
        rpos   = pos(is8, 6'(f_cur - npt));
        opos   = pos(is8, 6'(f_cur - off));
    end

    // Row pass: tr[u][n] = sum_v X[u][v] * C(v,n).
    // Column pass: x[m][n] = sum_u C(u,m) * tr[u][n].
    always_comb begin
        a_row = '0;
        c_row = '0;
        a_col = '0;
        c_col = '0;
        for (int i = 0; i < 8; i++) begin
            a_row[i*16 +: 16] = xin[rpos[5:3]][3'(i)];
            c_row[i*14 +: 14] = coef(is8, 3'(i), rpos[2:0]);
            a_col[i*16 +: 16] = tr[3'(i)][opos[2:0]];
            c_col[i*14 +: 14] = coef(is8, 3'(i), opos[5:3]);
        end
    end

    idct_mac_row u_row (
        .a (a_row),
        .c (c_row),
        .y (row_y)
    );

    idct_mac_row u_col (
        .a (a_col),
        .c (c_col),
        .y (col_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_4X4;
            f_cnt  <= '0;
            dout   <= '0;
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++) begin
                    xin[i][j] <= '0;
                    tr[i][j]  <= '0;
                end
        end else begin
            mode_q <= mode;
            f_cnt  <= f_nxt;
            dout   <= out_en ? col_y : '0;
            if (in_en)
                xin[ipos[5:3]][ipos[2:0]] <= data;
            if (row_en)
                tr[rpos[5:3]][rpos[2:0]] <= row_y;
        end
    end

endmodule

// File: tb/tb_idct_top.sv
// tb_idct_top: self-checking bench for idct_top against a floating-point
// derived reference (basis from $cos, separable row-then-column passes).
module tb_idct_top;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode  = 2'b00;
    logic [15:0] data  = '0;
    logic [15:0] dout;

    int checks = 0;
    int errors = 0;
    int xm [64];
    int ym [64];

    idct_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .data  (data),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    function automatic int cf(input int n, input int k, input int i);
        real a, v;
        a = (k == 0) ? $sqrt(1.0 / n) : $sqrt(2.0 / n);
        v = a * $cos((2 * i + 1) * k * 3.141592653589793 / (2 * n)) * 4096.0;
        return $rtoi(v + ((v < 0.0) ? -0.5 : 0.5));
    endfunction

    function automatic int lim(input longint s);
        longint r;
        r = (s + 2048) >>> 12;
`ifdef IDCT_SAT_EN
        return (r > 32767) ? 32767 : (r < -32768) ? -32768 : int'(r);
`else
        return int'(shortint'(r));
`endif
    endfunction

    task automatic ref_model(input int n);
        int     t [64];
        longint s;
        for (int u = 0; u < n; u++)
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int v = 0; v < n; v++)
                    s += longint'(xm[u*n+v]) * longint'(cf(n, v, j));
                t[u*n+j] = lim(s);
            end
        for (int m = 0; m < n; m++)
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int u = 0; u < n; u++)
                    s += longint'(cf(n, u, m)) * longint'(t[u*n+j]);
                ym[m*n+j] = lim(s);
            end
    endtask

    task automatic chk(input string tag, input int f, input int exp);
        checks++;
        assert (dout === 16'(exp)) else begin
            errors++;
            $error("FAIL %s f=%0d dout=%0d expected=%0d", tag, f, $signed(dout), exp);
        end
    endtask

    task automatic fill_rand(input int span);
        for (int i = 0; i < 64; i++)
            xm[i] = (span == 0) ? int'($signed(16'($urandom))) : int'($urandom_range(2 * span - 1)) - span;
    endtask

    task automatic fill_const(input int v0, input int rest);
        for (int i = 0; i < 64; i++)
            xm[i] = rest;
        xm[0] = v0;
    endtask

    // Drive one frame (or its first ncyc clocks) and check dout every clock.
    // pre inserts one reserved-mode clock so the frame is forced to start at f=0.
    task automatic frame(input string tag, input logic [1:0] md, input int ncyc,
                         input bit pre, input bit use_fix, input int fixv);
        int n, nsq, off, e;
        n   = (md == 2'b01) ? 8 : 4;
        nsq = n * n;
        off = (n == 8) ? 80 : 24;
        ref_model(n);
        if (pre) begin
            @(negedge clk);
            mode = 2'b10 + 2'($urandom_range(1));
            data = 16'($urandom);
            @(posedge clk);
            #1 chk("reserved", 0, 0);
        end
        for (int f = 0; f < ncyc; f++) begin
            @(negedge clk);
            mode = md;
            data = (f < nsq) ? 16'(xm[f]) : 16'($urandom);
            @(posedge clk);
            #1;
            e = (f >= off && f < off + nsq) ? (use_fix ? fixv : ym[f - off]) : 0;
            chk(tag, f, e);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk("reset", -1, 0);
        @(negedge clk);
        mode = 2'b01;
        data = 16'h1234;
        @(posedge clk);
        #1 chk("reset_hold", -1, 0);
        #1 rst_n = 1'b1;
        mode = 2'b00;

        fill_const(64, 0);
        frame("dc4", 2'b00, 45, 1'b0, 1'b1, 16);
        fill_const(64, 0);
        frame("dc8", 2'b01, 149, 1'b1, 1'b1, 8);
        fill_const(32767, 0);
        frame("dc8max_wrap", 2'b01, 149, 1'b0, 1'b1, 4095);
        fill_const(32767, 32767);
        frame("full4", 2'b00, 45, 1'b1, 1'b0, 0);

        fill_rand(0);
        frame("rand8a", 2'b01, 149, 1'b1, 1'b0, 0);
        fill_rand(256);
        frame("rand8b", 2'b01, 149, 1'b1, 1'b0, 0);
        fill_rand(0);
        frame("rand4a", 2'b00, 45, 1'b1, 1'b0, 0);
        fill_rand(1000);
        frame("rand4b", 2'b00, 45, 1'b0, 1'b0, 0);

        fill_rand(0);
        frame("abort8", 2'b01, 40, 1'b1, 1'b0, 0);
        fill_rand(0);
        frame("after_abort4", 2'b00, 45, 1'b0, 1'b0, 0);
        fill_rand(0);
        frame("after_abort4b", 2'b00, 45, 1'b0, 1'b0, 0);

        fill_rand(0);
        frame("pre_rst8", 2'b01, 91, 1'b1, 1'b0, 0);
        #1 rst_n = 1'b0;
        #1 chk("rst_async", 90, 0);
        @(posedge clk);
        #1 chk("rst_held", -1, 0);
        #1 rst_n = 1'b1;
        fill_rand(0);
        frame("post_rst4", 2'b00, 45, 1'b0, 1'b0, 0);
        fill_rand(0);
        frame("post_rst8", 2'b01, 149, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idct_top.md
IDCT_TOP -- requirements
Module: idct_top

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: mode  input  2  transform select: 2'b01 = 8x8 IDCT, 2'b00 = 4x4 IDCT, 2'b10/2'b11 reserved.
REQ-004 SHALL have ports: data  input  16  signed DCT coefficient, one per clock, row-major (frequency row u, column v).
REQ-005 SHALL have ports: dout  output  16  signed spatial sample, one per clock, row-major; registered.
REQ-006 SHALL have no parameters; block sizes are fixed by mode.

Function
REQ-007 SHALL run a frame counter f; f=0 on the first clock after reset release and on any clock where mode differs from its value on the previous clock; otherwise f increments and wraps.
REQ-008 Frame length: mode 01 -> 149 cycles; 64 input samples sampled at f=0..63. Mode 00 -> 45 cycles; 16 input samples sampled at f=0..15; data ignored at all other f.
REQ-009 Transform: x = C^T X C, C(k,n) = a(k)*cos((2n+1)k*pi/2N), a(0)=sqrt(1/N), a(k>0)=sqrt(2/N), N=8 or 4.
REQ-010 Constants: signed 14-bit, value round(C*4096).
REQ-011 Row pass: each intermediate = (sum of products + 2048) >>> 12 (arithmetic), then limited to 16 bits per REQ-019; accumulator at least 33 bits.
REQ-012 Column pass: same rounding/limiting applied to row-pass results; gives dout.
REQ-013 Output timing 8x8: spatial sample k (row-major, k=0..63) on dout at f=80+k.
REQ-014 Output timing 4x4: spatial sample k (k=0..15) on dout at f=24+k.
REQ-015 dout SHALL be 0 at every other f, in reserved modes, and while reset is asserted.
REQ-016 A mode change mid-frame SHALL abandon the current frame: no outputs from it; the new frame starts at f=0.
REQ-017 Reserved modes: f held at 0, data ignored, dout=0.

Reset
REQ-018 rst_n low SHALL immediately clear dout, f, all pipeline and transpose storage to 0 and abort any frame in progress.

Configuration
REQ-019 With macro IDCT_SAT_EN defined, every row- and column-pass result SHALL saturate to [-32768, 32767]; without it, results SHALL be truncated to 16 bits (two's-complement wrap).

Structure
REQ-020 A shared package idct_pkg SHALL hold: the 8-point and 4-point coefficient tables, the frame lengths (149, 45), the output start offsets (80, 24), the 12-bit fraction shift, and the mode encodings.
REQ-021 A single sub-module idct_mac_row SHALL compute one N-point dot product with round, shift and limit; it SHALL be instantiated for both the row pass and the column pass.
REQ-022 An 8x8x16-bit transpose register array SHALL separate the two passes; the 4x4 mode uses its upper-left quadrant.

Verification
REQ-023 Mode 01, X[0][0]=64, all others 0 -> all 64 outputs = 8, at f=80..143; dout=0 elsewhere.
REQ-024 Mode 00, X[0][0]=64, all others 0 -> all 16 outputs = 16, at f=24..39.
REQ-025 Mode 01, X[0][0]=32767, all others 0 -> all 64 outputs = 4095.
REQ-026 Mode 00, all 16 inputs = 32767 -> output sample 0 = 32767 with IDCT_SAT_EN; without the macro, the value equals the 16-bit-wrapped result.
REQ-027 Mode switched 01->00 at f=40 of an 8x8 frame -> no 8x8 outputs; the 4x4 frame restarts at f=0 and produces correct output at f=24.
REQ-028 rst_n pulsed low at f=90 of an 8x8 frame -> dout=0 at once; the next frame starts on the first clock after release.
